// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM request scheduler.
package jtframe_sdram_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
  typedef enum logic [1:0] {SRC_BANK, SRC_PROG, SRC_RFSH} src_t;
  localparam logic [1:0] PEND_MAX = 2'd3;
endpackage

// File: rtl/jtframe_rr_pick.sv
// Rotating-priority finder: first requester strictly after ptr wins, wrapping around.
module jtframe_rr_pick #(
  parameter int N  = 4,
  parameter int BW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [BW-1:0] ptr,
  output logic [BW-1:0] gnt_idx,
  output logic          gnt_any
);
  // Scan from farthest to nearest so the nearest requester after ptr is the last write.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_any = |req;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) gnt_idx = BW'(idx);
    end
  end
endmodule

// File: rtl/jtframe_sdram_mux.sv
// N-bank SDRAM request scheduler: prog > refresh > round-robin banks, one transaction in flight.
module jtframe_sdram_mux
  import jtframe_sdram_pkg::*;
#(
  parameter int               BANKS    = 4,
  parameter int               AW       = 22,
  parameter int               DW       = 16,
  parameter logic [BANKS-1:0] WRBANKS  = 'b0001,
  parameter int               RFSH_CNT = 384,
  parameter int               BW       = $clog2(BANKS)
) (
  input  logic                rst,
  input  logic                clk,
  input  logic [BANKS*AW-1:0] ba_addr,
  input  logic [BANKS-1:0]    ba_rd,
  input  logic [BANKS-1:0]    ba_wr,
  input  logic [BANKS*DW-1:0] ba_din,
  input  logic [BANKS*2-1:0]  ba_din_m,
  output logic [BANKS-1:0]    ba_ack,
  output logic [BANKS-1:0]    ba_rdy,
  output logic [2*DW-1:0]     sdram_dout,
  input  logic                prog_en,
  input  logic [AW-1:0]       prog_addr,
  input  logic [BW-1:0]       prog_ba,
  input  logic                prog_rd,
  input  logic                prog_we,
  input  logic [DW-1:0]       prog_data,
  input  logic [1:0]          prog_mask,
  output logic                prog_rdy,
  input  logic                rfsh_en,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [BW-1:0]       cmd_bank,
  output logic [AW-1:0]       cmd_addr,
  output logic                cmd_we,
  output logic                cmd_rfsh,
  output logic [DW-1:0]       cmd_din,
  output logic [1:0]          cmd_mask,
  input  logic                rsp_valid,
  input  logic [2*DW-1:0]     rsp_data
);
  localparam int RCW = (RFSH_CNT > 1) ? $clog2(RFSH_CNT) : 1;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [BW-1:0]     gnt_q, gnt_d, ptr_q, ptr_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [1:0]        pend_q, pend_d;
  logic              cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d, cmd_rfsh_q, cmd_rfsh_d;
  logic [BW-1:0]     cmd_bank_q, cmd_bank_d;
  logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]     cmd_din_q, cmd_din_d;
  logic [1:0]        cmd_mask_q, cmd_mask_d;
  logic [BANKS-1:0]  ack_q, ack_d, rdy_q, rdy_d;
  logic              prog_rdy_q, prog_rdy_d;
  logic [2*DW-1:0]   dout_q, dout_d;
  logic              rfsh_inc, rfsh_dec;

  // Write requests only count on banks allowed to write.
  logic [BANKS-1:0]  wr_ok, req;
  logic [BW-1:0]     pick_idx;
  logic              pick_any;

  assign wr_ok = ba_wr & WRBANKS;
  assign req   = ba_rd | wr_ok;

  jtframe_rr_pick #(.N(BANKS), .BW(BW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Scheduler FSM, command capture, refresh bookkeeping and completion pulses.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_we_d    = cmd_we_q;
    cmd_rfsh_d  = cmd_rfsh_q;
    cmd_din_d   = cmd_din_q;
    cmd_mask_d  = cmd_mask_q;
    ack_d       = '0;
    rdy_d       = '0;
    prog_rdy_d  = 1'b0;
    dout_d      = dout_q;
    pend_d      = pend_q;
    rfsh_dec    = 1'b0;
    rfsh_inc    = 1'b0;
    rcnt_d      = rcnt_q + 1'b1;
    if (rcnt_q == RCW'(RFSH_CNT - 1)) begin
      rcnt_d   = '0;
      rfsh_inc = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (prog_en && (prog_we || prog_rd)) begin
          src_d       = SRC_PROG;
          cmd_valid_d = 1'b1;
          cmd_bank_d  = prog_ba;
          cmd_addr_d  = prog_addr;
          cmd_we_d    = prog_we;
          cmd_rfsh_d  = 1'b0;
          cmd_din_d   = prog_data;
          cmd_mask_d  = prog_mask;
          state_d     = CMD;
        end else if (pend_q != 2'd0 && rfsh_en && !prog_en) begin
          src_d       = SRC_RFSH;
          cmd_valid_d = 1'b1;
          cmd_bank_d  = '0;
          cmd_addr_d  = '0;
          cmd_we_d    = 1'b0;
          cmd_rfsh_d  = 1'b1;
          cmd_din_d   = '0;
          cmd_mask_d  = '0;
          state_d     = CMD;
        end else if (!prog_en && pick_any) begin
          src_d       = SRC_BANK;
          gnt_d       = pick_idx;
          cmd_valid_d = 1'b1;
          cmd_bank_d  = pick_idx;
          cmd_addr_d  = ba_addr[int'(pick_idx)*AW +: AW];
          cmd_we_d    = wr_ok[pick_idx];
          cmd_rfsh_d  = 1'b0;
          cmd_din_d   = ba_din[int'(pick_idx)*DW +: DW];
          cmd_mask_d  = ba_din_m[int'(pick_idx)*2 +: 2];
          state_d     = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT;
          if (src_q == SRC_BANK) begin
            ptr_d        = gnt_q;
            ack_d[gnt_q] = 1'b1;
          end
          if (src_q == SRC_RFSH) rfsh_dec = 1'b1;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          state_d = IDLE;
          if (src_q == SRC_BANK) rdy_d[gnt_q] = 1'b1;
          if (src_q == SRC_PROG) prog_rdy_d = 1'b1;
          if (src_q != SRC_RFSH && !cmd_we_q) dout_d = rsp_data;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending refresh count saturates at PEND_MAX; a simultaneous +1/-1 cancels.
    case ({rfsh_inc, rfsh_dec})
      2'b10:   if (pend_q != PEND_MAX) pend_d = pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: ;
    endcase
  end

  // State registers; reset returns everything to idle with bank 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_BANK;
      gnt_q       <= '0;
      ptr_q       <= BW'(BANKS - 1);
      rcnt_q      <= '0;
      pend_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_we_q    <= 1'b0;
      cmd_rfsh_q  <= 1'b0;
      cmd_din_q   <= '0;
      cmd_mask_q  <= '0;
      ack_q       <= '0;
      rdy_q       <= '0;
      prog_rdy_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      rcnt_q      <= rcnt_d;
      pend_q      <= pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_we_q    <= cmd_we_d;
      cmd_rfsh_q  <= cmd_rfsh_d;
      cmd_din_q   <= cmd_din_d;
      cmd_mask_q  <= cmd_mask_d;
      ack_q       <= ack_d;
      rdy_q       <= rdy_d;
      prog_rdy_q  <= prog_rdy_d;
      dout_q      <= dout_d;
    end
  end

  assign ba_ack     = ack_q;
  assign ba_rdy     = rdy_q;
  assign prog_rdy   = prog_rdy_q;
  assign sdram_dout = dout_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_bank   = cmd_bank_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_we     = cmd_we_q;
  assign cmd_rfsh   = cmd_rfsh_q;
  assign cmd_din    = cmd_din_q;
  assign cmd_mask   = cmd_mask_q;
endmodule

// File: tb/tb_jtframe_sdram_mux.sv
// Scoreboard bench for jtframe_sdram_mux: stimulus pushes expectations, monitor pops and compares.
module tb_jtframe_sdram_mux;
  localparam int BANKS = 4, AW = 22, DW = 16, BW = 2, RFSH = 16;

  logic                rst = 1'b1, clk = 1'b0;
  logic [BANKS*AW-1:0] ba_addr = '0;
  logic [BANKS-1:0]    ba_rd = '0, ba_wr = '0;
  logic [BANKS*DW-1:0] ba_din = '0;
  logic [BANKS*2-1:0]  ba_din_m = '0;
  logic [BANKS-1:0]    ba_ack, ba_rdy;
  logic [2*DW-1:0]     sdram_dout;
  logic                prog_en = 0, prog_rd = 0, prog_we = 0;
  logic [AW-1:0]       prog_addr = '0;
  logic [BW-1:0]       prog_ba = '0;
  logic [DW-1:0]       prog_data = '0;
  logic [1:0]          prog_mask = '0;
  logic                prog_rdy;
  logic                rfsh_en = 0;
  logic                cmd_valid, cmd_ready = 0, cmd_we, cmd_rfsh;
  logic [BW-1:0]       cmd_bank;
  logic [AW-1:0]       cmd_addr;
  logic [DW-1:0]       cmd_din;
  logic [1:0]          cmd_mask;
  logic                rsp_valid = 0;
  logic [2*DW-1:0]     rsp_data = '0;

  jtframe_sdram_mux #(.BANKS(BANKS), .AW(AW), .DW(DW), .WRBANKS(4'b0001), .RFSH_CNT(RFSH)) dut (
    .rst(rst), .clk(clk), .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
    .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy), .sdram_dout(sdram_dout),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd),
    .prog_we(prog_we), .prog_data(prog_data), .prog_mask(prog_mask), .prog_rdy(prog_rdy),
    .rfsh_en(rfsh_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_rfsh(cmd_rfsh), .cmd_din(cmd_din),
    .cmd_mask(cmd_mask), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {bit rfsh; bit prog; bit we; logic [1:0] bank; logic [21:0] addr;
                  logic [15:0] din; logic [1:0] mask;} exp_cmd_t;
  typedef struct {bit prog; logic [1:0] bank; logic [31:0] data;} exp_rdy_t;

  exp_cmd_t    qc[$];
  int          qa[$];
  exp_rdy_t    qr[$];
  int          checks = 0, errors = 0, tmo = 0;
  bit          done = 0, chk_zero = 0, rdy_en = 1;
  int          eng_cnt = 0, rfsh_seen = 0, rfsh_stop = 0;
  logic [31:0] eng_data = '0, last_rd = '0;

  // Engine read data is a fixed function of the address.
  function automatic logic [31:0] rd_val(input logic [21:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  // One clock of stimulus: host drops requests on ack/rdy, engine answers 4 cycles after handshake.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < BANKS; i++)
      if (ba_ack[i]) begin ba_rd[i] = 1'b0; ba_wr[i] = 1'b0; end
    if (prog_rdy) begin prog_we = 1'b0; prog_rd = 1'b0; end
    cmd_ready = rdy_en;
    rsp_valid = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin rsp_valid = 1'b1; rsp_data = eng_data; end
    end
    if (cmd_valid && cmd_ready) begin
      eng_cnt  = 4;
      eng_data = rd_val(cmd_addr);
      if (cmd_rfsh) begin
        rfsh_seen++;
        if (rfsh_seen == rfsh_stop) rfsh_en = 1'b0;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    step();
    while ((qc.size() + qa.size() + qr.size()) != 0 && n < budget) begin step(); n++; end
    if (n >= budget) tmo++;
  endtask

  task automatic push_bank(input int b, input bit we, input logic [21:0] a, input logic [15:0] d,
                           input logic [1:0] m, input bit want_rdy);
    qc.push_back('{rfsh:1'b0, prog:1'b0, we:we, bank:2'(b), addr:a, din:d, mask:m});
    qa.push_back(b);
    if (want_rdy) begin
      if (!we) last_rd = rd_val(a);
      qr.push_back('{prog:1'b0, bank:2'(b), data:last_rd});
    end
    ba_addr[b*AW +: AW] = a;
    ba_din[b*DW +: DW]  = d;
    ba_din_m[b*2 +: 2]  = m;
    if (we) ba_wr[b] = 1'b1; else ba_rd[b] = 1'b1;
  endtask

  task automatic push_prog(input bit we, input logic [21:0] a, input logic [1:0] ba,
                           input logic [15:0] d, input logic [1:0] m);
    qc.push_back('{rfsh:1'b0, prog:1'b1, we:we, bank:ba, addr:a, din:d, mask:m});
    if (!we) last_rd = rd_val(a);
    qr.push_back('{prog:1'b1, bank:2'd0, data:last_rd});
    prog_addr = a; prog_ba = ba; prog_data = d; prog_mask = m;
    if (we) prog_we = 1'b1; else prog_rd = 1'b1;
  endtask

  task automatic push_rfsh();
    qc.push_back('{rfsh:1'b1, prog:1'b0, we:1'b0, bank:2'd0, addr:22'd0, din:16'd0, mask:2'd0});
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stimulus: directed scenarios.
  initial begin
    steps(2);
    chk_zero = 1; step(); chk_zero = 0;
    rst = 1'b0;
    step();

    // Round robin over all four banks, then 0 and 2 again with ptr at 3.
    for (int i = 0; i < BANKS; i++) push_bank(i, 1'b0, 22'h100 + 22'(i), 16'h0, 2'b00, 1'b1);
    drain(200);
    push_bank(0, 1'b0, 22'h3A000, 16'h0, 2'b00, 1'b1);
    push_bank(2, 1'b0, 22'h00007, 16'h0, 2'b00, 1'b1);
    drain(100);

    // Write on a writable bank; bank 1 write is not permitted and must never be acked.
    ba_addr[1*AW +: AW] = 22'h00555; ba_wr[1] = 1'b1;
    push_bank(0, 1'b1, 22'h12345, 16'hBEEF, 2'b10, 1'b1);
    drain(100);
    steps(10);
    ba_wr[1] = 1'b0;

    // Download port has absolute priority; bank 2 waits until prog_en drops.
    prog_en = 1'b1;
    ba_addr[2*AW +: AW] = 22'h2F00F; ba_rd[2] = 1'b1;
    push_prog(1'b1, 22'h00200, 2'd1, 16'h1234, 2'b00);
    drain(100);
    push_prog(1'b1, 22'h00201, 2'd3, 16'h5678, 2'b01);
    drain(100);
    push_prog(1'b0, 22'h00203, 2'd0, 16'h0000, 2'b00);
    drain(100);
    steps(5);
    prog_en = 1'b0;
    qc.push_back('{rfsh:1'b0, prog:1'b0, we:1'b0, bank:2'd2, addr:22'h2F00F, din:16'd0, mask:2'd0});
    qa.push_back(2);
    last_rd = rd_val(22'h2F00F);
    qr.push_back('{prog:1'b0, bank:2'd2, data:last_rd});
    drain(100);

    // Refresh backlog saturates at 3 and all three run ahead of a bank request.
    steps(64);
    push_rfsh(); push_rfsh(); push_rfsh();
    push_bank(1, 1'b0, 22'h0ABCD, 16'h0, 2'b00, 1'b1);
    rfsh_seen = 0; rfsh_stop = 3; rfsh_en = 1'b1;
    drain(200);

    // Engine stalls: command must stay put and ack follows the handshake by one cycle.
    rdy_en = 1'b0;
    push_bank(3, 1'b0, 22'h3FFFFF, 16'h0, 2'b00, 1'b1);
    steps(12);
    rdy_en = 1'b1;
    drain(100);

    // Reset while waiting on the engine: the late response must be ignored.
    push_bank(2, 1'b0, 22'h00155, 16'h0, 2'b00, 1'b0);
    begin
      int n;
      n = 0;
      step();
      while (qa.size() != 0 && n < 50) begin step(); n++; end
      if (n >= 50) tmo++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0; chk_zero = 1; last_rd = '0;
    step();
    chk_zero = 0;
    steps(8);
    push_bank(0, 1'b0, 22'h00011, 16'h0, 2'b00, 1'b1);
    push_bank(2, 1'b0, 22'h00022, 16'h0, 2'b00, 1'b1);
    drain(100);
    steps(4);
    done = 1;
  end

  // Monitor: samples just before each rising edge and checks against the scoreboard.
  initial begin
    bit       hs_prev;
    bit [3:0] acked;
    hs_prev = 0;
    acked   = '0;
    forever begin
      @(negedge clk); #4;
      if (chk_zero) begin
        chk("reset_outputs", 64'({ba_ack, ba_rdy, prog_rdy, cmd_valid, cmd_rfsh, cmd_we,
                                 cmd_bank, cmd_addr, cmd_din, cmd_mask}), 64'd0);
        chk("reset_dout", 64'(sdram_dout), 64'd0);
        acked   = '0;
        hs_prev = 0;
      end
      if (|ba_ack || hs_prev) chk("ack_timing", 64'(|ba_ack), 64'(hs_prev));
      if (|ba_ack) begin
        int idx;
        idx = 0;
        for (int i = 0; i < BANKS; i++) if (ba_ack[i]) idx = i;
        chk("ack_onehot", 64'($onehot(ba_ack)), 64'd1);
        if (qa.size() == 0) chk("ack_unexpected", 64'(ba_ack), 64'd0);
        else begin
          chk("ack_bank", 64'(idx), 64'(qa.pop_front()));
          acked[idx] = 1'b1;
        end
      end
      if (|ba_rdy || prog_rdy) begin
        int idx;
        idx = 0;
        for (int i = 0; i < BANKS; i++) if (ba_rdy[i]) idx = i;
        chk("rdy_onehot", 64'($onehot({ba_rdy, prog_rdy})), 64'd1);
        if (qr.size() == 0) chk("rdy_unexpected", 64'({ba_rdy, prog_rdy}), 64'd0);
        else begin
          exp_rdy_t e;
          e = qr.pop_front();
          chk("rdy_src_prog", 64'(prog_rdy), 64'(e.prog));
          if (!e.prog) begin
            chk("rdy_bank", 64'(idx), 64'(e.bank));
            chk("ack_before_rdy", 64'(acked[idx]), 64'd1);
            acked[idx] = 1'b0;
          end
          chk("rdy_dout", 64'(sdram_dout), 64'(e.data));
        end
      end
      hs_prev = 0;
      if (cmd_valid) begin
        if (qc.size() == 0) chk("cmd_unexpected", 64'(cmd_valid), 64'd0);
        else begin
          exp_cmd_t e;
          e = qc[0];
          chk("cmd_rfsh", 64'(cmd_rfsh), 64'(e.rfsh));
          chk("cmd_we", 64'(cmd_we), 64'(e.we));
          if (!e.rfsh) begin
            chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            chk("cmd_bank", 64'(cmd_bank), 64'(e.bank));
          end
          if (e.we) begin
            chk("cmd_din", 64'(cmd_din), 64'(e.din));
            chk("cmd_mask", 64'(cmd_mask), 64'(e.mask));
          end
          if (cmd_ready) begin
            void'(qc.pop_front());
            hs_prev = !e.rfsh && !e.prog;
          end
        end
      end
      if (done) break;
    end
    chk("queues_empty", 64'(qc.size() + qa.size() + qr.size()), 64'd0);
    chk("wait_timeouts", 64'(tmo), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the scenario sequencing itself wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
